rgb565_dvp8_tx: RTL
===================

Name: rgb565_dvp8_tx

Overview:
- Transmitter end of the 8-bit DVP camera interface. Takes a 16-bit RGB565 pixel stream over a valid/ready handshake.
- Serializes each pixel into two bytes, high byte first, so a DVP receiver packing {first,second} rebuilds the original word.
- Generates vs_o/de_o frame timing from internal counters.
- Used as a camera emulator / loopback source for exercising the capture path without a sensor.

Parameters:
- H_ACTIVE, 1024, pixels per active line (2*H_ACTIVE byte cycles with de_o high).
- V_ACTIVE, 768, active lines per frame.
- H_BLANK, 64, byte cycles per line with de_o low after the active bytes (>=1).
- VS_LINES, 2, lines with vs_o high at frame start (>=1).
- V_BACK, 4, blank lines between vsync and the first active line (>=0).
- V_FRONT, 4, blank lines after the last active line (>=0).

Ports:
- pclk  input  1  byte clock; single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- tx_en  input  1  frame enable; sampled only at frame boundaries.
- pix_valid  input  1  pixel available.
- pix_data  input  16  RGB565 pixel.
- pix_sof  input  1  marks the first pixel of a frame; used only with SOF_SYNC_EN.
- pix_ready  output  1  pixel accepted when pix_valid & pix_ready at a pclk edge.
- vs_o  output  1  vertical sync, active high.
- de_o  output  1  href/data enable.
- pdata_o  output  8  DVP byte.
- frame_done  output  1  one-cycle pulse at the end of the V_FRONT region.
- underflow  output  1  sticky flag: an active pixel slot found no valid pixel.

Behaviour:
- Reset (async, rst_n low): vs_o, de_o, pdata_o, frame_done, underflow = 0. FSM goes to IDLE; hcnt, vcnt and byte phase are cleared.
- Reset asserted mid-frame aborts immediately, with no flush.
- Line length L = 2*H_ACTIVE + H_BLANK cycles. hcnt counts 0..L-1 and wraps. vcnt counts lines within a region.
- All outputs except pix_ready are registered.
- FSM states:
  - IDLE: outputs low. Move to VSYNC when tx_en=1.
  - VSYNC: vs_o=1 for VS_LINES*L cycles. Then V_BACK, or ACTIVE if V_BACK=0.
  - V_BACK: vs_o=0, de_o=0 for V_BACK*L cycles. Then ACTIVE.
  - ACTIVE: for hcnt < 2*H_ACTIVE, de_o=1. For the rest of the line, de_o=0 and pdata_o=0. After V_ACTIVE lines, go to V_FRONT (or frame end if V_FRONT=0).
  - V_FRONT: blank lines. On the last cycle, pulse frame_done. Then go to VSYNC if tx_en=1, else IDLE.
- Byte phase in ACTIVE with de_o region: phase toggles every cycle, starting at 0 on hcnt=0.
  - pix_ready = (state==ACTIVE) & (hcnt<2*H_ACTIVE) & (phase==0). pix_ready is combinational from state regs only, never from pix_valid.
  - Phase 0 with handshake: pdata_o <= pix_data[15:8] and pix_data[7:0] is held in a register. Next cycle (phase 1): pdata_o <= held low byte.
  - Latency: pixel accepted at edge t; high byte visible after edge t, low byte after edge t+1, both with de_o=1.
  - Phase 0 without pix_valid: emit 0x00 and 0x00, de_o stays 1, underflow <= 1. Timing is never stretched.
- underflow clears only on reset.
- tx_en dropping mid-frame does not abort; the current frame completes.
- pix_ready=0 outside active slots. The upstream source holds data.
- Pixels accepted per frame = exactly H_ACTIVE*V_ACTIVE when there is no underflow.

Optional Feature:
- SOF_SYNC_EN defined: IDLE and the frame-boundary transition wait for alignment.
  - pix_ready=1 in IDLE, and stale pixels with pix_sof=0 are discarded.
  - A pixel with pix_sof=1 is not consumed; the FSM enters VSYNC, and that pixel becomes the first active pixel.
  - In ACTIVE, an accepted pixel with pix_sof=1 that is not the frame's first pixel sets underflow, and the pixel is still transmitted.
- SOF_SYNC_EN undefined: pix_sof is ignored, and frames free-run from tx_en.

Test Plan:
- Bench parameters: H_ACTIVE=4, V_ACTIVE=2, H_BLANK=3, VS_LINES=1, V_BACK=1, V_FRONT=1 (L=11).
- Case 1: tx_en=1, always-valid pixels 0x1234,0x5678,... -> vs_o high for 11 cycles, 11 blank cycles, then de_o high for 8 cycles with bytes 12,34,56,78,..., then 3 low. Repeat for line 2. frame_done pulses once after 11 front-porch cycles.
- Case 2: pix_valid low for the 2nd pixel slot of line 1 -> bytes 12,34,00,00,... with de_o held high, underflow=1 and staying 1.
- Case 3: backpressure check -> pix_ready high exactly 4 cycles per active line, on alternate cycles. 8 pixels consumed per frame.
- Case 4: tx_en dropped during line 1 -> frame completes, frame_done pulses, FSM returns to IDLE with outputs 0.
- Case 5: rst_n pulsed low mid-ACTIVE -> all outputs 0 asynchronously. After release with tx_en=1, a fresh VSYNC starts.
- Case 6 (SOF_SYNC_EN): feed 3 pixels with sof=0, then 0xABCD with sof=1 -> the first three are dropped, and the first active bytes are AB,CD.

Source files
------------

// File: rtl/rgb565_dvp8_tx.sv
// rgb565_dvp8_tx: RGB565 pixel stream to 8-bit DVP transmitter.
// Each accepted pixel goes out as two bytes, high byte first, with vs_o/de_o
// framing generated from internal line/pixel counters.
// Optional build macro SOF_SYNC_EN: frames start only on a pixel marked with
// pix_sof, and stale pixels are discarded while waiting for alignment.
//
// Handshake: a pixel transfers on a pclk edge where pix_valid & pix_ready;
// pix_ready never depends on pix_valid, and the source holds data while
// pix_ready is low.
module rgb565_dvp8_tx #(
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768,
    parameter int H_BLANK  = 64,
    parameter int VS_LINES = 2,
    parameter int V_BACK   = 4,
    parameter int V_FRONT  = 4
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        tx_en,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    input  logic        pix_sof,
    output logic        pix_ready,
    output logic        vs_o,
    output logic        de_o,
    output logic [7:0]  pdata_o,
    output logic        frame_done,
    output logic        underflow
);
    localparam int L_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int HW    = $clog2(L_LEN);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBACK  = 3'd2,
        S_ACTIVE = 3'd3,
        S_VFRONT = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [15:0]     vcnt_q, vcnt_d;
    logic            phase_q, phase_d;
    logic [7:0]      lo_q, lo_d;
    logic [7:0]      pdata_q, pdata_d;
    logic            vs_q, vs_d;
    logic            de_q, de_d;
    logic            fd_q, fd_d;
    logic            uf_q, uf_d;

    logic            line_end;
    logic            act_slot;
    logic            frame_end;
    logic            start_ok;
    logic            restart;

    assign line_end = (hcnt_q == HW'(L_LEN - 1));
    assign act_slot = (state_q == S_ACTIVE) && (hcnt_q < HW'(2 * H_ACTIVE));

`ifdef SOF_SYNC_EN
    // Idle drains stale pixels but never consumes the start-of-frame pixel;
    // that one is held upstream and becomes the first active pixel.
    assign pix_ready = (act_slot & ~phase_q) | ((state_q == S_IDLE) & ~pix_sof);
    assign start_ok  = tx_en & pix_valid & pix_sof;
    // Every frame realigns through idle on the next marked pixel.
    assign restart   = 1'b0;
`else
    logic sof_unused;
    assign sof_unused = pix_sof;
    assign pix_ready  = act_slot & ~phase_q;
    assign start_ok   = tx_en;
    assign restart    = tx_en;
`endif

    // Frame sequencer: region state plus pixel and line counters.
    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        frame_end = 1'b0;
        if (state_q != S_IDLE) begin
            hcnt_d = line_end ? '0 : hcnt_q + HW'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_VSYNC;
                    hcnt_d  = '0;
                    vcnt_d  = '0;
                end
            end
            S_VSYNC: begin
                if (line_end) begin
                    if (vcnt_q == 16'(VS_LINES - 1)) begin
                        vcnt_d  = '0;
                        state_d = (V_BACK == 0) ? S_ACTIVE : S_VBACK;
                    end else begin
                        vcnt_d = vcnt_q + 16'd1;
                    end
                end
            end
            S_VBACK: begin
                if (line_end) begin
                    if (vcnt_q == 16'(V_BACK - 1)) begin
                        vcnt_d  = '0;
                        state_d = S_ACTIVE;
                    end else begin
                        vcnt_d = vcnt_q + 16'd1;
                    end
                end
            end
            S_ACTIVE: begin
                if (line_end) begin
                    if (vcnt_q == 16'(V_ACTIVE - 1)) begin
                        vcnt_d = '0;
                        if (V_FRONT == 0) frame_end = 1'b1;
                        else              state_d   = S_VFRONT;
                    end else begin
                        vcnt_d = vcnt_q + 16'd1;
                    end
                end
            end
            S_VFRONT: begin
                if (line_end) begin
                    if (vcnt_q == 16'(V_FRONT - 1)) frame_end = 1'b1;
                    else                            vcnt_d    = vcnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (frame_end) begin
            state_d = restart ? S_VSYNC : S_IDLE;
            hcnt_d  = '0;
            vcnt_d  = '0;
        end
    end

    // Registered outputs: byte serializer, sync flags and sticky underflow.
    always_comb begin
        vs_d    = (state_q == S_VSYNC);
        de_d    = act_slot;
        fd_d    = frame_end;
        pdata_d = 8'h00;
        lo_d    = lo_q;
        uf_d    = uf_q;
        phase_d = 1'b0;
        if (act_slot) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                if (pix_valid) begin
                    pdata_d = pix_data[15:8];
                    lo_d    = pix_data[7:0];
`ifdef SOF_SYNC_EN
                    if (pix_sof && !(vcnt_q == 16'd0 && hcnt_q == '0)) uf_d = 1'b1;
`endif
                end else begin
                    // Missing pixel: keep timing, send a black pixel.
                    lo_d = 8'h00;
                    uf_d = 1'b1;
                end
            end else begin
                pdata_d = lo_q;
            end
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            phase_q <= 1'b0;
            lo_q    <= 8'h00;
            pdata_q <= 8'h00;
            vs_q    <= 1'b0;
            de_q    <= 1'b0;
            fd_q    <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            phase_q <= phase_d;
            lo_q    <= lo_d;
            pdata_q <= pdata_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            fd_q    <= fd_d;
            uf_q    <= uf_d;
        end
    end

    assign vs_o       = vs_q;
    assign de_o       = de_q;
    assign pdata_o    = pdata_q;
    assign frame_done = fd_q;
    assign underflow  = uf_q;

endmodule
